// File: rtl/arb_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the first set req bit after 'last' (mod 8) wins.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] win_onehot,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] pick;
    logic             found;
    logic [ID_W-1:0]  idx;

    always_comb begin
        rot        = '0;
        pick       = '0;
        found      = 1'b0;
        idx        = '0;
        win_onehot = '0;
        win_id     = '0;

        // rot[0] is the requester right after the previous owner
        for (int i = 0; i < N_REQ; i++) begin
            idx    = ID_W'(i) + last + ID_W'(1);
            rot[i] = req[idx];
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end

        for (int i = 0; i < N_REQ; i++) begin
            idx             = ID_W'(i) + last + ID_W'(1);
            win_onehot[idx] = pick[i];
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (win_onehot[i]) begin
                win_id = win_id | ID_W'(i);
            end
        end

        any = |req;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot/encoded grant and an
// optional per-owner hold limit that revokes long-held grants.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             revoked
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

    arb_state_t       state, state_n;
    logic [ID_W-1:0]  last, last_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic             gnt_valid_n;
    logic             revoked_n;

    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_id;
    logic             any;

    rr_pick8 u_pick (
        .req        (req),
        .last       (last),
        .win_onehot (win_onehot),
        .win_id     (win_id),
        .any        (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= ID_W'(N_REQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            revoked   <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            gnt_id    <= gnt_id_n;
            gnt_valid <= gnt_valid_n;
            revoked   <= revoked_n;
        end
    end

    always_comb begin
        state_n     = state;
        last_n      = last;
        cnt_n       = cnt;
        gnt_n       = gnt;
        gnt_id_n    = gnt_id;
        gnt_valid_n = gnt_valid;
        revoked_n   = 1'b0;

        case (state)
            IDLE: begin
                if (any) begin
                    state_n     = GRANT;
                    gnt_n       = win_onehot;
                    gnt_id_n    = win_id;
                    gnt_valid_n = 1'b1;
                    last_n      = win_id;
                    cnt_n       = '0;
                end else begin
                    gnt_n       = '0;
                    gnt_id_n    = '0;
                    gnt_valid_n = 1'b0;
                end
            end
            GRANT: begin
                // Release is checked first so it masks a coincident timeout
                if (!req[gnt_id]) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_id_n    = '0;
                    gnt_valid_n = 1'b0;
                end else if ((MAX_HOLD != 0) && (cnt == LIMIT)) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_id_n    = '0;
                    gnt_valid_n = 1'b0;
                    revoked_n   = 1'b1;
                end else if (cnt != '1) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_n       = '0;
                gnt_id_n    = '0;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic against a
// cycle-level reference model of owner, pointer and hold time.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       revoked;

  logic [7:0] req0;
  logic [7:0] gnt0;
  logic [2:0] gnt_id0;
  logic       gnt_valid0;
  logic       revoked0;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_owner;    // -1 when no grant
  int m_last;
  int m_held;     // cycles the current grant has been visible
  bit m_revoked;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .revoked   (revoked)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req0),
    .gnt       (gnt0),
    .gnt_id    (gnt_id0),
    .gnt_valid (gnt_valid0),
    .revoked   (revoked0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 7;
    m_held    = 0;
    m_revoked = 1'b0;
  endtask

  function automatic int model_winner(input logic [7:0] r, input int lst);
    for (int k = 1; k <= 8; k++) begin
      if (r[(lst + k) % 8]) return (lst + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] r);
    if (m_owner < 0) begin
      m_revoked = 1'b0;
      if (r != 8'h00) begin
        m_owner = model_winner(r, m_last);
        m_last  = m_owner;
        m_held  = 1;
      end
    end else if (!r[m_owner]) begin
      m_owner   = -1;
      m_revoked = 1'b0;
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      m_owner   = -1;
      m_revoked = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [7:0] exp_gnt();
    return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
  endfunction

  task automatic compare_model();
    check("gnt",       gnt,              exp_gnt());
    check("gnt_id",    {5'b0, gnt_id},   (m_owner < 0) ? 8'h00 : 8'(m_owner));
    check("gnt_valid", {7'b0, gnt_valid}, {7'b0, (m_owner >= 0)});
    check("revoked",   {7'b0, revoked},   {7'b0, m_revoked});
  endtask

  // driver: one clock, update model on the same edge, compare 1 time unit later
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(req);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin : main
    int         seq[$];
    int         exp_rot[6];
    int         waited;
    int         first_hold;
    int         rev_count;
    int         dut0_bad;
    int         dut0_rev;
    bit         seen_rev;

    // reset with all requests high: outputs must stay zero
    rst_n = 1'b0;
    req   = 8'hFF;
    req0  = 8'h00;
    model_reset();
    step();
    step();
    check("rst_gnt",       gnt,                8'h00);
    check("rst_gnt_id",    {5'b0, gnt_id},     8'h00);
    check("rst_gnt_valid", {7'b0, gnt_valid},  8'h00);
    check("rst_revoked",   {7'b0, revoked},    8'h00);
    rst_n = 1'b1;
    step();
    check("first_gnt",    gnt,            8'h01);
    check("first_gnt_id", {5'b0, gnt_id}, 8'h00);
    req = 8'h00;
    step();
    step();

    // single requester
    req = 8'h20;
    step();
    check("single_gnt",    gnt,            8'h20);
    check("single_gnt_id", {5'b0, gnt_id}, 8'h05);
    repeat (4) step();
    req = 8'h00;
    step();
    check("single_drop", gnt, 8'h00);
    step();

    // rotation: each owner holds 2 cycles, drops 1 cycle, reasserts
    do_reset();
    exp_rot = '{0, 3, 7, 0, 3, 7};
    req = 8'h89;
    for (int g = 0; g < 6; g++) begin
      waited = 0;
      step();
      while (!gnt_valid && waited < 20) begin
        step();
        waited++;
      end
      check("rot_wait", {7'b0, gnt_valid}, 8'h01);
      seq.push_back(int'(gnt_id));
      step();
      req[gnt_id] = 1'b0;
      step();
      req = 8'h89;
    end
    for (int g = 0; g < 6; g++) begin
      check($sformatf("rot_order_%0d", g), 8'(seq[g]), 8'(exp_rot[g]));
    end
    seq.delete();

    // simultaneous after reset
    req = 8'h00;
    do_reset();
    req = 8'h84;
    step();
    check("simul_first", {5'b0, gnt_id}, 8'h02);
    step();
    req = 8'h80;
    step();
    step();
    check("simul_second", {5'b0, gnt_id}, 8'h07);
    req = 8'h00;
    step();

    // timeout: req[3] held 40 cycles, req[5] from cycle 2; compare limited vs unlimited
    do_reset();
    req0 = 8'h00;
    step();
    first_hold = 0;
    rev_count  = 0;
    dut0_bad   = 0;
    dut0_rev   = 0;
    seen_rev   = 1'b0;
    req  = 8'h08;
    req0 = 8'h08;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) req = 8'h28;
      step();
      if (gnt_valid && (seq.size() == 0 || revoked === 1'b0 && seq[$] != int'(gnt_id) ||
                        seq.size() == 0)) begin
        if (seq.size() == 0 || seq[$] != int'(gnt_id)) seq.push_back(int'(gnt_id));
      end
      if (!seen_rev && gnt === 8'h08) first_hold++;
      if (revoked) begin
        rev_count++;
        seen_rev = 1'b1;
      end
      if (gnt0 !== 8'h08) dut0_bad++;
      if (revoked0) dut0_rev++;
    end
    check("to_first_hold", 8'(first_hold), 8'd16);
    check("to_rev_count",  8'(rev_count),  8'd2);
    check("to_seq_len",    8'(seq.size()), 8'd3);
    if (seq.size() >= 3) begin
      check("to_seq0", 8'(seq[0]), 8'd3);
      check("to_seq1", 8'(seq[1]), 8'd5);
      check("to_seq2", 8'(seq[2]), 8'd3);
    end
    check("nolimit_gnt",     8'(dut0_bad), 8'd0);
    check("nolimit_revoked", 8'(dut0_rev), 8'd0);
    seq.delete();
    req  = 8'h00;
    req0 = 8'h00;
    step();
    step();

    // async reset between edges while requester 6 owns the resource
    do_reset();
    req = 8'h40;
    step();
    check("async_pre", gnt, 8'h40);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_gnt",       gnt,               8'h00);
    check("async_gnt_valid", {7'b0, gnt_valid}, 8'h00);
    check("async_gnt_id",    {5'b0, gnt_id},    8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("async_regrant", gnt, 8'h40);
    req = 8'h00;
    step();
    step();

    // random traffic: requests change on roughly a quarter of cycles
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
